// File: rtl/systolic_drain_if.sv
// Row-stream interface between systolic_drain and its downstream consumer.
// Parameters must match the systolic_drain instance that uses it.
//   row_data_o : N elements of one result row, element j in bits of index j
//   row_idx_o  : index of the row currently presented
//   valid_o    : a beat is presented this cycle
//   last_o     : the presented row is row N-1
//   ready_i    : consumer accepts the beat when valid_o && ready_i at clk rise
// Modports: master = drain side, slave = consumer side.
interface systolic_drain_if #(
  parameter int NUM_BITS = 8,
  parameter int N        = 4
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0][NUM_BITS-1:0] row_data_o;
  logic [RW-1:0]              row_idx_o;
  logic                       valid_o;
  logic                       last_o;
  logic                       ready_i;

  modport master (
    output row_data_o, row_idx_o, valid_o, last_o,
    input  ready_i
  );

  modport slave (
    input  row_data_o, row_idx_o, valid_o, last_o,
    output ready_i
  );
endinterface

// File: rtl/systolic_drain.sv
// systolic_drain: result-side companion of the systolic array.
// On a done_i pulse the whole N x N result matrix is copied into a local
// snapshot, then streamed out one row per beat over a valid/ready interface,
// so the array can start its next tile while the results drain.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous, active-high reset
//   C_i       : result matrix, C_i[r][c]; sampled only on an accepted done_i
//   done_i    : one-cycle pulse, C_i is final this cycle
//   row_if    : row stream (master side), see systolic_drain_if
//   busy_o    : a snapshot is held and being streamed
//   overrun_o : one-cycle pulse, a done_i arrived mid-stream and was dropped
module systolic_drain #(
  parameter int NUM_BITS = 8,
  parameter int N        = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N-1:0][N-1:0][NUM_BITS-1:0]  C_i,
  input  logic                               done_i,
  systolic_drain_if.master                   row_if,
  output logic                               busy_o,
  output logic                               overrun_o
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                            state_q, state_d;
  logic [RW-1:0]                     row_q, row_d;
  logic                              overrun_q, overrun_d;
  logic                              capture;
  logic                              handshake;
  logic                              at_last;
  logic [N-1:0][N-1:0][NUM_BITS-1:0] snap_q;

  assign handshake = (state_q == STREAM) && row_if.ready_i;
  assign at_last   = (row_q == LAST_ROW);

  // Next-state logic. A done_i is accepted in IDLE, or in STREAM only on the
  // cycle the final row completes its handshake; that back-to-back case
  // recaptures and restarts at row 0 with no idle bubble. Any other done_i
  // during STREAM is dropped and reported on overrun_o.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    row_d     = row_q;
    overrun_d = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (done_i) begin
          capture = 1'b1;
          row_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (handshake && at_last) begin
          row_d = '0;
          if (done_i) capture = 1'b1;
          else        state_d = IDLE;
        end else begin
          if (handshake) row_d = row_q + RW'(1);
          if (done_i)    overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: the snapshot is reset deliberately so row_data_o reads zero out of
  // reset; a buffer with no such requirement would normally be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          snap_q <= '0;
    else if (capture) snap_q <= C_i;
  end

  // All outputs come straight from registers, so a stalled beat holds stable
  // and reset clears them without waiting for a clock edge.
  assign row_if.valid_o    = (state_q == STREAM);
  assign row_if.last_o     = (state_q == STREAM) && at_last;
  assign row_if.row_idx_o  = row_q;
  assign row_if.row_data_o = snap_q[row_q];
  assign busy_o            = (state_q == STREAM);
  assign overrun_o         = overrun_q;

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Result-side companion to `top_lvl`, the systolic array. It consumes the array's N x N `C_o` result matrix.
- On a completion pulse it snapshots the whole matrix into a local buffer. It then streams the matrix out one row per beat over a valid/ready interface to downstream logic (writeback, host, or bench scoreboard).
- Snapshotting frees the array to start the next tile while results drain.

Parameters:
- NUM_BITS, 8, width of one result element; matches the array's element width.
- N, 4, array dimension; N x N results, N elements per output row; N >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- C_i  input  [NUM_BITS-1:0] x [N][N]  result matrix from array `C_o`; sampled only on an accepted done_i.
- done_i  input  1  single-cycle pulse: C_i is final and valid this cycle.
- row_data_o  output  [NUM_BITS-1:0] x [N]  current row; element j = snapshot[row][j].
- row_idx_o  output  RW bits  index of current row, RW = (N>1) ? $clog2(N) : 1.
- valid_o  output  1  row_data_o/row_idx_o/last_o valid.
- ready_i  input  1  downstream accepts beat when valid_o && ready_i.
- last_o  output  1  high with valid_o on row N-1.
- busy_o  output  1  high while a snapshot is held (state STREAM).
- overrun_o  output  1  one-cycle pulse: done_i arrived and was dropped.

Behaviour:
- Reset values (async, immediate on rst high): state IDLE, valid_o 0, last_o 0, busy_o 0, overrun_o 0, row_idx_o 0, row_data_o 0, snapshot buffer 0.
- FSM states: IDLE, STREAM.
- IDLE:
  - done_i=1 -> capture all N*N elements of C_i into buffer at that edge, row counter 0, go STREAM.
  - valid_o rises the cycle after done_i (latency 1).
- STREAM:
  - valid_o=1, busy_o=1, row_data_o = buffer row at counter.
  - Handshake = valid_o && ready_i at a rising edge. No handshake -> all outputs hold stable.
  - valid_o never drops without a handshake.
  - Handshake with counter < N-1 -> counter +1, stay STREAM; next row presented the following cycle (back-to-back beats at ready_i=1, one row per cycle).
  - Handshake with counter == N-1 (last_o=1) -> transfer complete:
    - done_i=0 same cycle -> IDLE, valid_o=0 next cycle, counter 0.
    - done_i=1 same cycle -> accepted: recapture C_i, counter 0, stay STREAM. valid_o stays 1, next cycle shows row 0 of new snapshot. No bubble, no overrun.
  - done_i=1 in STREAM without a final handshake that cycle -> dropped: buffer unchanged, overrun_o=1 for exactly the next cycle, stream continues unaffected.
- Full transfer at ready_i held 1: N beats in cycles 1..N after done_i.
- N=1: every beat has last_o=1, row_idx_o=0.
- ready_i ignored in IDLE. ready_i may be high before valid_o.
- Reset mid-stream: outputs go to reset values immediately. The partially sent matrix is discarded and never resumed.
- No arithmetic on data; elements pass bit-exact, unsigned/signed agnostic.

Test Plan:
- N=4, NUM_BITS=8, C_i[r][c]=16*r+c, done_i pulse at t0, ready_i=1 -> rows 0..3 on cycles t0+1..t0+4. Row 2 data = {0x20,0x21,0x22,0x23}. last_o only with row_idx_o=3. valid_o=0 at t0+5.
- Same stimulus, ready_i toggling 1,0,0,1,... -> row_data_o/row_idx_o stable while stalled. Exactly 4 beats, in order, no duplicates. C_i changed after t0 has no effect.
- done_i again while row 1 is stalled -> overrun_o high one cycle. Remaining rows still from the first matrix. busy_o stays 1.
- done_i with new matrix (all 0xFF) on the same cycle as the row-3 handshake -> next cycle valid_o=1, row_idx_o=0, data all 0xFF. overrun_o stays 0. 8 total beats, no bubble.
- rst asserted asynchronously mid-cycle during row 2 -> valid_o, busy_o, last_o drop immediately. After release, no beats until the next done_i, whose stream starts at row 0.
- N=1 build: done_i with C_i=0x5A -> single beat, row_idx_o=0, last_o=1, data 0x5A, then IDLE.
